vga_ram_arbiter: RTL and testbench
==================================

// Module: vga_ram_arbiter
// PURPOSE
// Sole owner of the VGA frame RAM write port (16x12 cells, 3-bit colour).
// Shares it between the CPU VGA instruction path and the keyboard echo path.
// Round-robin arbitration; optional write gating to vertical blank.
// A built-in clear sequencer fills the whole RAM with one colour on request.
// The scan-out read port is not touched: the VGA engine keeps reading freely.
// PARAMETERS
// ADDR_W       8       frame RAM address width
// DATA_W       3       colour width {R,B,G}
// DEPTH        192     valid cells (16*12); addresses >= DEPTH are invalid
// CLEAR_COLOR  3'b000  value written by the clear sequencer
// VBLANK_ONLY  0       1: requester writes are granted only while iVBlank=1
// PORTS
// Clock        in   1       system clock
// Reset_n      in   1       reset, asynchronous, active-low
// iCpuReq      in   1       CPU write request; held high until oCpuAck
// iCpuAddr     in   ADDR_W  CPU write address; stable while iCpuReq=1
// iCpuData     in   DATA_W  CPU write colour; stable while iCpuReq=1
// oCpuAck      out  1       one-cycle pulse: CPU request consumed
// iKbdReq      in   1       keyboard write request; same rules as CPU
// iKbdAddr     in   ADDR_W  keyboard write address
// iKbdData     in   DATA_W  keyboard write colour
// oKbdAck      out  1       one-cycle pulse: keyboard request consumed
// iVBlank      in   1       high during vertical blank (from VGA timing)
// iClearReq    in   1       single-cycle pulse: start the clear sequencer
// oClearBusy   out  1       high while the clear sequencer owns the port
// oRamWe       out  1       frame RAM write enable (registered)
// oRamAddr     out  ADDR_W  frame RAM write address (registered)
// oRamData     out  DATA_W  frame RAM write data (registered)
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset (Reset_n=0), any time, including mid-clear:
//   - all outputs go to 0; FSM goes to IDLE.
//   - round-robin pointer set so the CPU wins the first tie.
//   - the clear in progress is aborted; it is not resumed.
// - FSM states: IDLE, WRITE, CLEAR. Encodings live in the shared definitions include.
// - IDLE / WRITE, evaluated every cycle:
//   - iClearReq=1 -> CLEAR. The pulse is taken even if a request is pending.
//   - else pick an eligible requester -> WRITE.
//     - Eligible: req=1, not masked, and (VBLANK_ONLY=0 or iVBlank=1).
//     - Both eligible: grant the one NOT granted last, then flip the pointer.
//     - One eligible: grant it; pointer = that requester.
//   - else -> IDLE.
// - Grant timing:
//   - the cycle after sampling, oRamWe, oRamAddr, oRamData and the granted
//     requester's ack are all high or valid together (latency 1).
//   - a requester whose ack is high is masked that cycle, so a held req is
//     never written twice. Per requester: at most one grant per 2 cycles.
//   - the other requester may be granted in the masked cycle.
//   - port throughput: up to one write per cycle.
// - Invalid address (addr >= DEPTH): ack is still pulsed, but oRamWe=0.
//   oRamAddr/oRamData still show the captured values.
// - CLEAR:
//   - oClearBusy=1 from the cycle after iClearReq.
//   - oRamWe=1 with addresses 0,1,...,DEPTH-1 on consecutive cycles;
//     data = CLEAR_COLOR.
//   - VBLANK_ONLY gating does not apply; the clear ignores iVBlank.
//   - oClearBusy drops the cycle after address DEPTH-1 is written.
//   - FSM returns to IDLE, and requesters may be granted that same cycle.
//   - requests during CLEAR stall: no ack, and requesters keep req high.
//   - iClearReq while oClearBusy=1 is ignored; the sequence is not restarted.
// - Outside a grant or clear: oRamWe=0; oRamAddr/oRamData hold their last value.
// - Counter width is ADDR_W. The clear counter never wraps past DEPTH-1.
// STRUCTURE
// - State encodings and the default DEPTH/CLEAR_COLOR go in the shared
//   definitions include alongside the opcode defines.
// - One sub-module: vga_clear_seq.
//   - inputs: start; outputs: busy, addr, last.
//   - contains the address counter.
// - The arbiter FSM, round-robin pointer, ack masks and output registers
//   stay in this module.
// TESTING
// 1. Reset mid-clear:
//    - stimulus: iClearReq, then Reset_n=0 at address 50.
//    - response: outputs 0 immediately; after release, oRamWe stays 0
//      with no requests pending.
// 2. Single CPU write:
//    - stimulus: iCpuReq, addr 8'd17, data 3'b011.
//    - response: the next cycle oRamWe=1, oRamAddr=17, oRamData=3'b011
//      and oCpuAck=1; no second write while req is held.
// 3. Contention:
//    - stimulus: both requests held high continuously.
//    - response: grants go CPU, KBD, CPU, KBD..., one write every cycle,
//      and each ack is high on alternate cycles.
// 4. Clear:
//    - stimulus: iClearReq pulse.
//    - response: 192 consecutive writes, addresses 0..191, data 3'b000;
//      oClearBusy is high for exactly 192 cycles.
//    - with iKbdReq held throughout: no oKbdAck until oClearBusy=0,
//      then the write is granted.
// 5. Invalid address:
//    - stimulus: iCpuAddr=8'd200.
//    - response: oCpuAck=1, oRamWe=0.
// 6. VBLANK_ONLY=1:
//    - stimulus: iCpuReq with iVBlank=0 for 10 cycles.
//    - response: no ack; when iVBlank rises, ack and write follow 1 cycle later.

Source files
------------

// File: rtl/vga_ram_arbiter_pkg.sv
// Shared definitions for the VGA frame RAM write arbiter: FSM state
// encodings and the default frame geometry / clear colour.
package vga_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_t;

    // 16 columns x 12 rows of colour cells
    localparam int         DEFAULT_DEPTH       = 192;
    localparam logic [2:0] DEFAULT_CLEAR_COLOR = 3'b000;

endpackage

// File: rtl/vga_clear_seq.sv
// Clear sequencer: walks the address counter from 0 to DEPTH-1, one cell per
// cycle, after a start pulse. 'last' flags the final address so the arbiter
// can hand the port back on the following edge.
module vga_clear_seq #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    assign last = busy && (addr == LAST_ADDR);

    // Address counter: a start while busy is ignored, the count stops at DEPTH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            addr <= '0;
        end else if (busy) begin
            if (addr == LAST_ADDR) begin
                busy <= 1'b0;
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end else if (start) begin
            busy <= 1'b1;
            addr <= '0;
        end
    end

endmodule

// File: rtl/vga_ram_arbiter.sv
// Sole owner of the VGA frame RAM write port. Shares it round-robin between
// the CPU and keyboard-echo requesters, optionally only during vertical blank,
// and lets a built-in clear sequencer flood the RAM with one colour.
module vga_ram_arbiter
    import vga_ram_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 3,
    parameter int                DEPTH       = DEFAULT_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = DATA_W'(DEFAULT_CLEAR_COLOR),
    parameter bit                VBLANK_ONLY = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              iCpuReq,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuData,
    output logic              oCpuAck,
    input  logic              iKbdReq,
    input  logic [ADDR_W-1:0] iKbdAddr,
    input  logic [DATA_W-1:0] iKbdData,
    output logic              oKbdAck,
    input  logic              iVBlank,
    input  logic              iClearReq,
    output logic              oClearBusy,
    output logic              oRamWe,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic [DATA_W-1:0] oRamData
);

    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);

    arb_state_t        state, state_next;
    logic              kbd_last, kbd_last_next;
    logic              we_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              cpu_ack_next, kbd_ack_next;
    logic              cpu_ok, kbd_ok, grant_cpu, grant_kbd;
    logic              clear_start, clear_busy, clear_last;
    logic [ADDR_W-1:0] clear_addr;

    vga_clear_seq #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk  (Clock),
        .rst_n(Reset_n),
        .start(clear_start),
        .busy (clear_busy),
        .addr (clear_addr),
        .last (clear_last)
    );

    assign oClearBusy = clear_busy;

    // State register; reset also aborts any clear, since the sequencer shares the reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grant choice and next values of the registered write port
    always_comb begin
        state_next    = ST_IDLE;
        kbd_last_next = kbd_last;
        we_next       = 1'b0;
        addr_next     = oRamAddr;
        data_next     = oRamData;
        cpu_ack_next  = 1'b0;
        kbd_ack_next  = 1'b0;
        clear_start   = 1'b0;
        grant_cpu     = 1'b0;
        grant_kbd     = 1'b0;

        cpu_ok = iCpuReq && !oCpuAck && (!VBLANK_ONLY || iVBlank);
        kbd_ok = iKbdReq && !oKbdAck && (!VBLANK_ONLY || iVBlank);

        if (state == ST_CLEAR && !clear_last) begin
            state_next = ST_CLEAR;
            we_next    = 1'b1;
            addr_next  = clear_addr + ADDR_W'(1);
            data_next  = CLEAR_COLOR;
        end else if (state != ST_CLEAR && iClearReq) begin
            state_next  = ST_CLEAR;
            clear_start = 1'b1;
            we_next     = 1'b1;
            addr_next   = '0;
            data_next   = CLEAR_COLOR;
        end else begin
            if (cpu_ok && kbd_ok) begin
                grant_cpu = kbd_last;
                grant_kbd = !kbd_last;
            end else begin
                grant_cpu = cpu_ok;
                grant_kbd = kbd_ok;
            end

            if (grant_cpu) begin
                state_next    = ST_WRITE;
                kbd_last_next = 1'b0;
                cpu_ack_next  = 1'b1;
                we_next       = (iCpuAddr < DEPTH_LIMIT);
                addr_next     = iCpuAddr;
                data_next     = iCpuData;
            end else if (grant_kbd) begin
                state_next    = ST_WRITE;
                kbd_last_next = 1'b1;
                kbd_ack_next  = 1'b1;
                we_next       = (iKbdAddr < DEPTH_LIMIT);
                addr_next     = iKbdAddr;
                data_next     = iKbdData;
            end
        end
    end

    // Registered write port, acks and round-robin pointer (reset lets the CPU win the first tie)
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            kbd_last <= 1'b1;
            oRamWe   <= 1'b0;
            oRamAddr <= '0;
            oRamData <= '0;
            oCpuAck  <= 1'b0;
            oKbdAck  <= 1'b0;
        end else begin
            kbd_last <= kbd_last_next;
            oRamWe   <= we_next;
            oRamAddr <= addr_next;
            oRamData <= data_next;
            oCpuAck  <= cpu_ack_next;
            oKbdAck  <= kbd_ack_next;
        end
    end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed bench for vga_ram_arbiter: one instance with free-running writes
// and one with writes gated to vertical blank, both driven by the same inputs.
module tb_vga_ram_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_req, kbd_req, vblank, clear_req;
    logic [7:0] cpu_addr, kbd_addr;
    logic [2:0] cpu_data, kbd_data;

    logic       cpu_ack, kbd_ack, busy, we;
    logic [7:0] addr;
    logic [2:0] data;

    logic       vb_cpu_ack, vb_kbd_ack, vb_busy, vb_we;
    logic [7:0] vb_addr;
    logic [2:0] vb_data;

    int err_count   = 0;
    int check_count = 0;

    // 100 MHz system clock
    always #5 clock = ~clock;

    vga_ram_arbiter dut (
        .Clock(clock), .Reset_n(reset_n),
        .iCpuReq(cpu_req), .iCpuAddr(cpu_addr), .iCpuData(cpu_data), .oCpuAck(cpu_ack),
        .iKbdReq(kbd_req), .iKbdAddr(kbd_addr), .iKbdData(kbd_data), .oKbdAck(kbd_ack),
        .iVBlank(vblank), .iClearReq(clear_req), .oClearBusy(busy),
        .oRamWe(we), .oRamAddr(addr), .oRamData(data)
    );

    vga_ram_arbiter #(.VBLANK_ONLY(1'b1)) dut_vb (
        .Clock(clock), .Reset_n(reset_n),
        .iCpuReq(cpu_req), .iCpuAddr(cpu_addr), .iCpuData(cpu_data), .oCpuAck(vb_cpu_ack),
        .iKbdReq(kbd_req), .iKbdAddr(kbd_addr), .iKbdData(kbd_data), .oKbdAck(vb_kbd_ack),
        .iVBlank(vblank), .iClearReq(clear_req), .oClearBusy(vb_busy),
        .oRamWe(vb_we), .oRamAddr(vb_addr), .oRamData(vb_data)
    );

    // Compares one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives every requester-side input in one go
    task automatic applyStimulus(input logic c_req, input logic [7:0] c_addr, input logic [2:0] c_data,
                                 input logic k_req, input logic [7:0] k_addr, input logic [2:0] k_data,
                                 input logic vb, input logic clr);
        cpu_req   = c_req;
        cpu_addr  = c_addr;
        cpu_data  = c_data;
        kbd_req   = k_req;
        kbd_addr  = k_addr;
        kbd_data  = k_data;
        vblank    = vb;
        clear_req = clr;
    endtask

    // Advances one clock and settles just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Safety net so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        bit found;

        reset_n = 1'b0;
        applyStimulus(0, 8'd0, 3'd0, 0, 8'd0, 3'd0, 0, 0);
        #2;
        checkOutput("reset_we", we, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_acks", {cpu_ack, kbd_ack}, 0);
        tick();
        tick();
        reset_n = 1'b1;

        // Test 1: reset in the middle of a clear
        $display("[TB] test 1: reset mid-clear");
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (addr == 8'd50) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("clear_reach_50", found, 1);
        checkOutput("clear_busy_at_50", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_we", we, 0);
        checkOutput("rst_mid_addr", addr, 0);
        checkOutput("rst_mid_data", data, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_acks", {cpu_ack, kbd_ack}, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("post_rst_we", we, 0);
            checkOutput("post_rst_busy", busy, 0);
        end

        // Test 3: both requesters held, CPU wins first tie then strict alternation
        $display("[TB] test 3: contention");
        applyStimulus(1, 8'd10, 3'd1, 1, 8'd20, 3'd6, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("cont_we", we, 1);
            checkOutput("cont_cpu_ack", cpu_ack, (i % 2 == 0) ? 1 : 0);
            checkOutput("cont_kbd_ack", kbd_ack, (i % 2 == 0) ? 0 : 1);
            checkOutput("cont_addr", addr, (i % 2 == 0) ? 10 : 20);
            checkOutput("cont_data", data, (i % 2 == 0) ? 1 : 6);
        end
        applyStimulus(0, 8'd10, 3'd1, 0, 8'd20, 3'd6, 0, 0);
        tick();
        checkOutput("cont_end_we", we, 0);

        // Test 2: single CPU write, held request not written twice
        $display("[TB] test 2: single CPU write");
        applyStimulus(1, 8'd17, 3'b011, 0, 8'd20, 3'd6, 0, 0);
        tick();
        checkOutput("cpu_we", we, 1);
        checkOutput("cpu_addr", addr, 17);
        checkOutput("cpu_data", data, 3);
        checkOutput("cpu_ack", cpu_ack, 1);
        checkOutput("cpu_kbd_ack", kbd_ack, 0);
        tick();
        checkOutput("cpu_masked_we", we, 0);
        checkOutput("cpu_masked_ack", cpu_ack, 0);
        checkOutput("cpu_hold_addr", addr, 17);
        cpu_req = 1'b0;

        // Test 5: invalid address is acknowledged but not written
        $display("[TB] test 5: invalid address");
        applyStimulus(1, 8'd200, 3'd5, 0, 8'd20, 3'd6, 0, 0);
        tick();
        checkOutput("inv_ack", cpu_ack, 1);
        checkOutput("inv_we", we, 0);
        checkOutput("inv_addr", addr, 200);
        checkOutput("inv_data", data, 5);
        cpu_req = 1'b0;
        tick();
        checkOutput("inv_after_ack", cpu_ack, 0);

        // Test 4: full clear with the keyboard stalled behind it
        $display("[TB] test 4: clear");
        applyStimulus(0, 8'd0, 3'd0, 1, 8'd33, 3'd2, 0, 1);
        for (int k = 0; k < 192; k++) begin
            tick();
            clear_req = (k == 100);
            checkOutput("clr_addr", addr, k);
            checkOutput("clr_we_busy_ack_data", {we, busy, kbd_ack, data}, {1'b1, 1'b1, 1'b0, 3'b000});
        end
        clear_req = 1'b0;
        tick();
        checkOutput("clr_done_busy", busy, 0);
        checkOutput("clr_kbd_ack", kbd_ack, 1);
        checkOutput("clr_kbd_we", we, 1);
        checkOutput("clr_kbd_addr", addr, 33);
        checkOutput("clr_kbd_data", data, 2);
        checkOutput("clr_vb_busy", vb_busy, 0);
        kbd_req = 1'b0;
        tick();

        // Test 6: vblank-gated instance holds off until vertical blank
        $display("[TB] test 6: vblank gating");
        applyStimulus(1, 8'd42, 3'd7, 0, 8'd0, 3'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("vb_wait_ack", vb_cpu_ack, 0);
            checkOutput("vb_wait_we", vb_we, 0);
        end
        vblank = 1'b1;
        tick();
        checkOutput("vb_ack", vb_cpu_ack, 1);
        checkOutput("vb_we", vb_we, 1);
        checkOutput("vb_addr", vb_addr, 42);
        checkOutput("vb_data", vb_data, 7);
        applyStimulus(0, 8'd0, 3'd0, 0, 8'd0, 3'd0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
